arith_compare_top: RTL and testbench

// - Small registered arithmetic/compare unit: adds, subtracts or magnitude-compares
//   two unsigned operands, selected per cycle by a 2-bit opcode.
// - Produces a WIDTH-bit result and a 3-bit relation flag vector {GT,EQ,LT}.
// - Used as a leaf datapath block; all outputs are registered, one clock domain.
//

---
 rtl/arith_compare_pkg.sv | 15 +
 rtl/arith_compare_magnitude_comparator.sv | 24 ++
 rtl/arith_compare_top.sv | 84 ++++++++
 tb/tb_arith_compare_top.sv | 119 +++++++++++
 4 files changed

// File: rtl/arith_compare_pkg.sv
// Shared definitions for the arith_compare slice.
// - Opcode encodings for the 2-bit ctrl input.
// - Bit positions inside the 3-bit relation flag vector {GT,EQ,LT}.
package arith_compare_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

endpackage

// File: rtl/arith_compare_magnitude_comparator.sv
// Combinational unsigned magnitude comparator.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : a >  b
//   eq   : a == b
//   lt   : a <  b
// Exactly one of gt/eq/lt is high for any pair of known operands.
module magnitude_comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/arith_compare_top.sv
// Registered add / subtract / compare unit.
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset, clears result and flag
//   A, B   : WIDTH-bit unsigned operands
//   ctrl   : opcode (ADD, SUB, CMP, reserved)
//   result : registered WIDTH-bit result, wraps modulo 2^WIDTH
//   flag   : registered one-hot relation {A>B, A==B, A<B}
// One cycle latency, a new operation every cycle, no handshake.
module arith_compare_top
  import arith_compare_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flag
);

  // Both helpers keep only the low WIDTH bits: the carry out of ADD and the
  // borrow out of SUB are intentionally dropped (modular arithmetic).
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    s = a + b;
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    return d;
  endfunction

  logic             gt_p0;
  logic             eq_p0;
  logic             lt_p0;
  logic [WIDTH-1:0] result_p0;
  logic [2:0]       flag_p0;

  magnitude_comparator #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a  (A),
    .b  (B),
    .gt (gt_p0),
    .eq (eq_p0),
    .lt (lt_p0)
  );

  // Stage p0: combinational opcode mux and flag assembly
  always_comb begin
    result_p0 = '0;
    unique case (ctrl)
      OP_ADD:  result_p0 = wrap_add(A, B);
      OP_SUB:  result_p0 = wrap_sub(A, B);
      OP_CMP:  result_p0 = '0;
      OP_RSV:  result_p0 = '0;
      default: result_p0 = '0;
    endcase

    flag_p0          = 3'b000;
    flag_p0[FLAG_GT] = gt_p0;
    flag_p0[FLAG_EQ] = eq_p0;
    flag_p0[FLAG_LT] = lt_p0;
  end

  // Stage p1: output registers; reset wins over any operation in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flag   <= 3'b000;
    end else begin
      result <= result_p0;
      flag   <= flag_p0;
    end
  end

endmodule

// File: tb/tb_arith_compare_top.sv
// Directed bench for arith_compare_top (WIDTH=4). Each step drives inputs on
// the falling edge and checks the registered outputs 1 time unit after the
// following rising edge, i.e. exactly one cycle after the inputs were applied.
module tb_arith_compare_top;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] ctrl;
  logic [3:0] result;
  logic [2:0] flag;

  int vectors;
  int miscompares;

  arith_compare_top #(
    .WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .ctrl   (ctrl),
    .result (result),
    .flag   (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] c);
    @(negedge clk);
    rst  = r;
    A    = a;
    B    = b;
    ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_r,
                       input logic [2:0] exp_f);
    vectors++;
    assert (result === exp_r) else begin
      miscompares++;
      $error("FAIL %s result: observed %b expected %b", tag, result, exp_r);
    end
    vectors++;
    assert (flag === exp_f) else begin
      miscompares++;
      $error("FAIL %s flag: observed %b expected %b", tag, flag, exp_f);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    A    = 4'd0;
    B    = 4'd0;
    ctrl = 2'b00;

    // Reset held for two cycles with live-looking operands
    step(1'b1, 4'b0101, 4'b0011, 2'b00);
    check("reset_c1", 4'b0000, 3'b000);
    step(1'b1, 4'b1111, 4'b0001, 2'b01);
    check("reset_c2", 4'b0000, 3'b000);

    // ADD, first operation after reset release
    step(1'b0, 4'b0101, 4'b0011, 2'b00);
    check("add_5_3", 4'b1000, 3'b100);
    step(1'b0, 4'b1111, 4'b0001, 2'b00);
    check("add_overflow", 4'b0000, 3'b100);

    // SUB
    step(1'b0, 4'b1001, 4'b0010, 2'b01);
    check("sub_9_2", 4'b0111, 3'b100);
    step(1'b0, 4'b0010, 4'b1111, 2'b01);
    check("sub_wrap", 4'b0011, 3'b001);

    // COMPARE
    step(1'b0, 4'b1010, 4'b0111, 2'b10);
    check("cmp_gt", 4'b0000, 3'b100);
    step(1'b0, 4'b0010, 4'b1111, 2'b10);
    check("cmp_lt", 4'b0000, 3'b001);
    step(1'b0, 4'b0101, 4'b0101, 2'b10);
    check("cmp_eq", 4'b0000, 3'b010);

    // Reserved opcode
    step(1'b0, 4'b0011, 4'b1001, 2'b11);
    check("rsv_lt", 4'b0000, 3'b001);

    // Back-to-back opcodes, one per cycle
    step(1'b0, 4'b0111, 4'b0110, 2'b00);
    check("b2b_add", 4'b1101, 3'b100);
    step(1'b0, 4'b0011, 4'b1000, 2'b01);
    check("b2b_sub", 4'b1011, 3'b001);
    step(1'b0, 4'b0100, 4'b0100, 2'b10);
    check("b2b_cmp", 4'b0000, 3'b010);
    step(1'b0, 4'b1100, 4'b0001, 2'b11);
    check("b2b_rsv", 4'b0000, 3'b100);

    // Establish a nonzero output, then reset alongside ADD 5+3
    step(1'b0, 4'b0110, 4'b0001, 2'b00);
    check("pre_midreset", 4'b0111, 3'b100);
    step(1'b1, 4'b0101, 4'b0011, 2'b00);
    check("midstream_reset", 4'b0000, 3'b000);

    // Recovery after mid-stream reset
    step(1'b0, 4'b0101, 4'b0011, 2'b00);
    check("post_reset_add", 4'b1000, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
